// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and master blocks.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_MACK,
        IGNORE
    } i2c_state_t;

    // Width of a register pointer for a register file of num_regs entries.
    function automatic int ptr_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Bus input synchroniser with START/STOP and SCL edge detection.
// Events are registered, so a bus edge shows up SYNC_STAGES+1 clk later.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s_o,
    output logic start_o,
    output logic stop_o,
    output logic scl_rise_o,
    output logic scl_fall_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_s, sda_s;
    logic scl_prev_q, sda_prev_q;
    logic start_q, stop_q, rise_q, fall_q;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Synchronise the bus lines and flag edges against the previous sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            start_q    <= scl_s & scl_prev_q & sda_prev_q & ~sda_s;
            stop_q     <= scl_s & scl_prev_q & ~sda_prev_q & sda_s;
            rise_q     <= scl_s & ~scl_prev_q;
            fall_q     <= ~scl_s & scl_prev_q;
        end
    end

    // sda_prev_q lines up with the registered events, so it is the bit to sample.
    assign sda_s_o    = sda_prev_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign scl_rise_o = rise_q;
    assign scl_fall_o = fall_q;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target with an internal register file, auto-incrementing pointer,
// repeated START support and silent handling of other addresses.
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDRESS = 7'h21,
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           scl_i,
    input  logic                           sda_i,
    output logic                           scl_o,
    output logic                           sda_o,
    output logic [NUM_REGS*I2C_BYTE_W-1:0] regs_o,
    output logic                           wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0]    wr_idx,
    output logic                           rd_strobe,
    output logic                           busy
);

    localparam int PW = ptr_width(NUM_REGS);

    logic sda_s, start_ev, stop_ev, rise_ev, fall_ev;

    i2c_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d, rx_byte;
    logic [PW-1:0] ptr_q, ptr_d, wr_idx_q;
    logic sda_q, sda_d, busy_q, busy_d, first_q, first_d, mack_q, mack_d;
    logic rd_strobe_q, rd_strobe_d, wr_en_d, wr_strobe_q;
    logic [NUM_REGS-1:0][I2C_BYTE_W-1:0] regs_q;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_s_o    (sda_s),
        .start_o    (start_ev),
        .stop_o     (stop_ev),
        .scl_rise_o (rise_ev),
        .scl_fall_o (fall_ev)
    );

    // Byte as it stands once the bit on the current rising edge is shifted in.
    assign rx_byte = {shift_q[I2C_BYTE_W-2:0], sda_s};

    // Next-state logic; START/STOP override any data edge in the same clk.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_d       = sda_q;
        busy_d      = busy_q;
        first_d     = first_q;
        mack_d      = mack_q;
        rd_strobe_d = 1'b0;
        wr_en_d     = 1'b0;
        if (start_ev) begin
            state_d = ADDR;
            cnt_d   = '0;
            sda_d   = 1'b1;
        end else if (stop_ev) begin
            state_d = IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (rise_ev && cnt_q < 4'd8) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (fall_ev && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        if (shift_q[7:1] == SLAVE_ADDRESS) begin
                            state_d = ADDR_ACK;
                            sda_d   = 1'b0;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (fall_ev) begin
                        if (shift_q[0]) begin
                            state_d     = RD_BYTE;
                            shift_d     = regs_q[ptr_q];
                            sda_d       = regs_q[ptr_q][7];
                            rd_strobe_d = 1'b1;
                        end else begin
                            state_d = WR_BYTE;
                            sda_d   = 1'b1;
                            first_d = 1'b1;
                        end
                    end
                end
                WR_BYTE: begin
                    if (rise_ev && cnt_q < 4'd8) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            first_d = 1'b0;
                            if (first_q) begin
                                ptr_d = rx_byte[PW-1:0];
                            end else begin
                                wr_en_d = 1'b1;
                                ptr_d   = ptr_q + 1'b1;
                            end
                        end
                    end else if (fall_ev && cnt_q == 4'd8) begin
                        state_d = WR_ACK;
                        sda_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                WR_ACK: begin
                    if (fall_ev) begin
                        state_d = WR_BYTE;
                        sda_d   = 1'b1;
                    end
                end
                RD_BYTE: begin
                    if (fall_ev) begin
                        if (cnt_q == 4'd7) begin
                            state_d = RD_MACK;
                            sda_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            shift_d = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                            sda_d   = shift_q[I2C_BYTE_W-2];
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                RD_MACK: begin
                    // Pointer advances on every byte sent, ACKed or not.
                    if (rise_ev) begin
                        mack_d = ~sda_s;
                        ptr_d  = ptr_q + 1'b1;
                    end else if (fall_ev) begin
                        if (mack_q) begin
                            state_d     = RD_BYTE;
                            shift_d     = regs_q[ptr_q];
                            sda_d       = regs_q[ptr_q][7];
                            rd_strobe_d = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Protocol state registers; reset releases SDA immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_q       <= 1'b1;
            busy_q      <= 1'b0;
            first_q     <= 1'b0;
            mack_q      <= 1'b0;
            rd_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_q       <= sda_d;
            busy_q      <= busy_d;
            first_q     <= first_d;
            mack_q      <= mack_d;
            rd_strobe_q <= rd_strobe_d;
        end
    end

    // Register file write port with its commit strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_idx_q    <= '0;
        end else begin
            wr_strobe_q <= wr_en_d;
            if (wr_en_d) begin
                regs_q[ptr_q] <= rx_byte;
                wr_idx_q      <= ptr_q;
            end
        end
    end

    assign scl_o     = 1'b1;
    assign sda_o     = sda_q;
    assign regs_o    = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_idx    = wr_idx_q;
    assign rd_strobe = rd_strobe_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench: bit-banged I2C master on an open-drain bus, transaction-level
// register model, and a per-cycle compare of the DUT outputs.
module tb_i2c_reg_slave;

    localparam int NR = 16;
    localparam logic [6:0] SADDR = 7'h21;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic scl_bus, sda_bus;
    logic scl_o, sda_o, wr_strobe, rd_strobe, busy;
    logic [NR*8-1:0] regs_o;
    logic [3:0] wr_idx;

    int n_chk = 0;
    int n_pass = 0;

    // Model: register contents and pointer as the protocol rules define them.
    logic [7:0] m_regs [NR];
    int m_ptr = 0;
    int exp_idx [$];
    logic [7:0] exp_dat [$];
    logic [7:0] shadow [NR];
    logic [7:0] tx [$];
    logic [7:0] rd_buf [4];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int last_wr_idx = -1;
    bit busy_seen = 1'b0;
    logic [NR*8-1:0] exp_vec;
    int c_idx;
    logic [7:0] c_dat;

    assign scl_bus = scl_m & scl_o;
    assign sda_bus = sda_m & sda_o;

    i2c_reg_slave #(.SLAVE_ADDRESS(SADDR), .NUM_REGS(NR), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_bus),
        .sda_i     (sda_bus),
        .scl_o     (scl_o),
        .sda_o     (sda_o),
        .regs_o    (regs_o),
        .wr_strobe (wr_strobe),
        .wr_idx    (wr_idx),
        .rd_strobe (rd_strobe),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    function automatic logic [NR*8-1:0] model_vec();
        logic [NR*8-1:0] v;
        for (int i = 0; i < NR; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    // Per-cycle compare: strobes against expected writes, full register file,
    // and the never-stretched SCL output.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) shadow[i] = 8'h00;
        end else begin
            if (wr_strobe) begin
                wr_cnt++;
                last_wr_idx = int'(wr_idx);
                if (exp_idx.size() == 0) begin
                    chk("wr_strobe_unexpected", wr_strobe, 1'b0);
                end else begin
                    c_idx = exp_idx.pop_front();
                    c_dat = exp_dat.pop_front();
                    chk("wr_idx", wr_idx, c_idx);
                    shadow[c_idx] = c_dat;
                end
            end
            if (rd_strobe) rd_cnt++;
            if (busy) busy_seen = 1'b1;
            for (int i = 0; i < NR; i++) exp_vec[8*i +: 8] = shadow[i];
            chk("regs_o", regs_o, exp_vec);
            chk("scl_o", scl_o, 1'b1);
        end
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START from idle or repeated START from SCL low.
    task automatic bus_start();
        sda_m = 1'b1; w(4);
        scl_m = 1'b1; w(6);
        sda_m = 1'b0; w(6);
        scl_m = 1'b0; w(5);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; w(6);
        scl_m = 1'b1; w(6);
        sda_m = 1'b1; w(8);
    endtask

    task automatic bit_x(input logic b, output logic s);
        sda_m = b;    w(6);
        scl_m = 1'b1; w(5);
        s = sda_bus;  w(5);
        scl_m = 1'b0; w(5);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        bit_x(1'b1, ack);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(1'b1, d[i]);
        bit_x(nack, s);
    endtask

    // Write transaction: address, pointer byte, then the bytes queued in tx.
    task automatic do_write(input logic [6:0] addr, input logic [7:0] pb);
        logic ack;
        bit m;
        m = (addr == SADDR);
        busy_seen = 1'b0;
        bus_start();
        wbyte({addr, 1'b0}, ack);
        chk("addr_ack", ack, m ? 1'b0 : 1'b1);
        if (m) begin
            wbyte(pb, ack);
            chk("ptr_ack", ack, 1'b0);
            m_ptr = int'(pb) % NR;
            foreach (tx[i]) begin
                exp_idx.push_back(m_ptr);
                exp_dat.push_back(tx[i]);
                m_regs[m_ptr] = tx[i];
                m_ptr = (m_ptr + 1) % NR;
                wbyte(tx[i], ack);
                chk("data_ack", ack, 1'b0);
            end
        end else begin
            foreach (tx[i]) begin
                wbyte(tx[i], ack);
                chk("ignored_nack", ack, 1'b1);
            end
        end
        bus_stop();
        chk("busy_seen", busy_seen, m);
        chk("busy_after_stop", busy, 1'b0);
        chk("regs_after_write", regs_o, model_vec());
    endtask

    task automatic read_data_bytes(input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            rbyte(i == n - 1, d);
            chk("rd_data", d, m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % NR;
            rd_buf[i] = d;
        end
        chk("sda_released_after_nack", sda_o, 1'b1);
    endtask

    // Optional pointer set, repeated START, then n bytes read.
    task automatic do_read(input bit set_ptr, input logic [7:0] pb, input int n);
        logic ack;
        int rd0;
        rd0 = rd_cnt;
        busy_seen = 1'b0;
        bus_start();
        if (set_ptr) begin
            wbyte({SADDR, 1'b0}, ack);
            chk("rd_addrw_ack", ack, 1'b0);
            wbyte(pb, ack);
            chk("rd_ptr_ack", ack, 1'b0);
            m_ptr = int'(pb) % NR;
            bus_start();
        end
        wbyte({SADDR, 1'b1}, ack);
        chk("rd_addrr_ack", ack, 1'b0);
        read_data_bytes(n);
        bus_stop();
        chk("rd_strobe_count", rd_cnt - rd0, n);
        chk("rd_busy_seen", busy_seen, 1'b1);
        chk("rd_busy_after_stop", busy, 1'b0);
    endtask

    initial begin
        logic s;
        logic [7:0] pb, rb;
        logic [6:0] a;
        int w0, n;
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 8'h00;
            shadow[i] = 8'h00;
        end

        w(3);
        chk("rst_sda_o", sda_o, 1'b1);
        chk("rst_scl_o", scl_o, 1'b1);
        chk("rst_regs_o", regs_o, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_strobe", wr_strobe, 1'b0);
        chk("rst_rd_strobe", rd_strobe, 1'b0);
        rst = 1'b0;
        w(5);

        // Single write
        w0 = wr_cnt;
        tx = '{8'h5A};
        do_write(SADDR, 8'h03);
        chk("t1_reg3", regs_o[3*8 +: 8], 8'h5A);
        chk("t1_wr_count", wr_cnt - w0, 1);
        chk("t1_wr_idx", last_wr_idx, 3);

        // Auto-increment with wrap
        tx = '{8'h11, 8'h22, 8'h33};
        do_write(SADDR, 8'h0E);
        chk("t2_reg14", regs_o[14*8 +: 8], 8'h11);
        chk("t2_reg15", regs_o[15*8 +: 8], 8'h22);
        chk("t2_reg0", regs_o[0 +: 8], 8'h33);

        // Repeated-START read across the wrap
        do_read(1'b1, 8'h0E, 3);
        chk("t3_rd0", rd_buf[0], 8'h11);
        chk("t3_rd1", rd_buf[1], 8'h22);
        chk("t3_rd2", rd_buf[2], 8'h33);

        // Address mismatch, with a stray data byte
        w0 = wr_cnt;
        tx = '{8'hFF};
        do_write(7'h42, 8'h00);
        chk("t4_no_write", wr_cnt - w0, 0);

        // STOP after 4 data bits
        w0 = wr_cnt;
        bus_start();
        wbyte({SADDR, 1'b0}, s);
        chk("t5_addr_ack", s, 1'b0);
        wbyte(8'h08, s);
        chk("t5_ptr_ack", s, 1'b0);
        m_ptr = 8;
        for (int i = 0; i < 4; i++) bit_x(1'b1, s);
        bus_stop();
        chk("t5_no_strobe", wr_cnt - w0, 0);
        chk("t5_busy", busy, 1'b0);
        tx = '{8'hA5};
        do_write(SADDR, 8'h01);
        chk("t5_reg1", regs_o[1*8 +: 8], 8'hA5);
        chk("t5_wr_count", wr_cnt - w0, 1);

        // Randomised mix of writes, reads and foreign-address traffic
        for (int it = 0; it < 20; it++) begin
            tx.delete();
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                rb = 8'($urandom);
                tx.push_back(rb);
            end
            pb = 8'($urandom);
            case ($urandom_range(0, 3))
                0, 1: do_write(SADDR, pb);
                2: do_read(1'($urandom_range(0, 1)), pb, $urandom_range(1, 4));
                default: begin
                    a = SADDR ^ 7'(1 << $urandom_range(0, 6));
                    do_write(a, pb);
                end
            endcase
        end

        // Reset while the slave is ACKing a read address
        bus_start();
        pb = {SADDR, 1'b1};
        for (int i = 7; i >= 0; i--) bit_x(pb[i], s);
        chk("t6_ack_driven", sda_o, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_sda_release", sda_o, 1'b1);
        chk("t6_rst_regs", regs_o, '0);
        chk("t6_rst_busy", busy, 1'b0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        w(3);
        rst = 1'b0;
        chk("t6_pending_writes", exp_idx.size(), 0);
        exp_idx.delete();
        exp_dat.delete();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        w(5);

        // Still functional after reset
        tx = '{8'hC3};
        do_write(SADDR, 8'h02);
        do_read(1'b1, 8'h02, 1);
        chk("t7_rd", rd_buf[0], 8'hC3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_reg_slave.md
# i2c_reg_slave

Parametrised I2C target with an internal register file. It supports both write and read transfers, a register pointer with auto-increment and wrap, repeated START and clean address-mismatch handling. It is the successor to the write-only `i2c_slave` and attaches to the same open-drain `scl`/`sda` bus used by the `i2c_master` bench model. System logic sees register contents continuously and gets one strobe per register written.

## Interface
Parameters:
- `SLAVE_ADDRESS`, default 7'h21: 7-bit target address.
- `NUM_REGS`, default 16: number of 8-bit registers, ≥2, power of two.
- `SYNC_STAGES`, default 2: synchroniser depth on `scl_i`/`sda_i`, ≥2.

Ports:
- `clk` in 1: system clock, at least 10× the SCL rate.
- `rst` in 1: asynchronous, active-high reset.
- `scl_i` in 1: bus SCL.
- `sda_i` in 1: bus SDA.
- `scl_o` out 1: open-drain SCL, 0 = pull low, 1 = release. This block never stretches, so it is tied to 1.
- `sda_o` out 1: open-drain SDA, 0 = pull low, 1 = release.
- `regs_o` out NUM_REGS*8: register file, flattened; reg k is bits [8k+7:8k].
- `wr_strobe` out 1: one-`clk` pulse when a data byte is committed to a register.
- `wr_idx` out $clog2(NUM_REGS): index written, valid while `wr_strobe` is high.
- `rd_strobe` out 1: one-`clk` pulse when a register is loaded for transmission.
- `busy` out 1: high from an addressed START (address match) until STOP.

## Operation
- **Synchroniser:** `scl_i` and `sda_i` pass through SYNC_STAGES flops, then an edge detector.
  - START = synced SDA falls while synced SCL is high.
  - STOP = synced SDA rises while synced SCL is high.
  - `sda_i` is sampled on the SCL rising edge. `sda_o` changes only on the SCL falling edge.
- **FSM states:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK, IGNORE.
- **START from any state** (including a repeated START) goes to ADDR. The bit counter clears and `sda_o` is released.
- **STOP from any state** goes to IDLE and releases `sda_o`. The pointer is retained.
- **ADDR:** shift in 8 bits, MSB first.
  - Bits [7:1] == SLAVE_ADDRESS: go to ADDR_ACK, assert `busy`.
  - Otherwise: go to IGNORE, leave `sda_o`=1 (NACK).
- **ADDR_ACK:** drive `sda_o`=0 for the 9th clock.
  - R/W=0: go to WR_BYTE; the first byte of the transfer is the pointer byte.
  - R/W=1: go to RD_BYTE and load the shift register with `regs[ptr]` (`rd_strobe` pulses).
- **WR_BYTE:** shift in 8 bits, then WR_ACK (always ACK).
  - Pointer byte: `ptr` = low $clog2(NUM_REGS) bits of the byte. Upper bits are ignored.
  - Data bytes: `regs[ptr]` ← byte, `wr_strobe`/`wr_idx`=ptr, then `ptr` ← (ptr+1) mod NUM_REGS.
- **RD_BYTE:** drive 8 bits MSB first, then release SDA for RD_MACK.
  - Master ACK (SDA=0 at the 9th rising edge): `ptr` increments with wrap, load the next register, return to RD_BYTE.
  - Master NACK: go to IGNORE with SDA released.
  - The read pointer advances after each byte sent, including a NACKed one.
- **IGNORE:** no bus activity until START or STOP.
- **Reset values:** `sda_o`=1, `scl_o`=1, `regs_o`=0, `ptr`=0, `wr_strobe`=0, `rd_strobe`=0, `busy`=0, state IDLE.
- **Reset mid-transfer:** releases the bus immediately, asynchronously.

## Timing
- **Input latency:** SYNC_STAGES+1 `clk` from a bus edge to its detected event.
- **`sda_o` updates:** the `clk` after the SCL-falling event. The 8th falling edge asserts ACK; the 9th falling edge releases it or drives the next read MSB.
- **Write commit:** `wr_strobe` and the `regs_o` update occur in the same `clk`, at the 8th SCL-rising event of the data byte.
- **Read load:** `rd_strobe` coincides with the load, at the falling edge ending ADDR_ACK or RD_MACK.
- **START/STOP vs data edge:** START/STOP detection takes priority over a data edge detected in the same `clk`.
- **Pointer wrap:** NUM_REGS-1 → 0, for both reads and writes.

## Structure
- **Package `i2c_pkg`:**
  - `i2c_state_t` enum.
  - `I2C_ADDR_W`=7 and `I2C_BYTE_W`=8.
  - Function computing the pointer width.
- **Sub-module `i2c_sync_edge`:** synchroniser plus START/STOP/SCL-rise/SCL-fall detection, parametrised by SYNC_STAGES. It is reused by the future master RTL.
- **Top level:** FSM, bit counter (4 bits), shift register, pointer and register file.

## Test plan
The bench extends `i2c_master` with a `read_data_bytes` task.
- **Single write:** write 7'h21, bytes 8'h03, 8'h5A → ACK on all 3 bytes; `regs[3]`=8'h5A; one `wr_strobe` with `wr_idx`=3.
- **Auto-increment wrap:** write 8'h0E, 8'h11, 8'h22, 8'h33 → `regs[14]`=8'h11, `regs[15]`=8'h22, `regs[0]`=8'h33.
- **Repeated-START read:** write pointer 8'h0E, repeated START, read 3 bytes (master ACK, ACK, NACK) → data 8'h11, 8'h22, 8'h33; SDA released after the NACK.
- **Address mismatch:** write to 7'h42 → 9th bit samples 1 (NACK); `regs_o` unchanged; `busy` stays 0.
- **STOP mid-byte:** STOP after 4 data bits → IDLE; no `wr_strobe`; the next write at pointer 8'h01 succeeds.
- **Reset mid-read:** assert `rst` while the slave drives SDA low → `sda_o`=1 within the same `clk`; `regs_o`=0.
